// File: rtl/mips32_arb_pkg.sv
// Shared types and constants for the mips32 unified memory arbiter.
package mips32_arb_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LD   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_IF   = 2'd3
  } req_id_e;

  // Bit positions inside the one-hot grant vector
  localparam int unsigned GNT_W  = 3;
  localparam int unsigned GNT_LD = 0;
  localparam int unsigned GNT_DM = 1;
  localparam int unsigned GNT_IF = 2;

endpackage

// File: rtl/mips32_arb_prio.sv
// Mode-aware priority picker: LD outside RUN, DM over IF in RUN unless IF has aged out.
module mips32_arb_prio
  import mips32_arb_pkg::*;
(
  input  state_e           state_i,
  input  logic             ld_req_i,
  input  logic             dm_req_i,
  input  logic             if_req_i,
  input  logic             age_i,
  output logic [GNT_W-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    case (state_i)
      BOOT, HALT: begin
        if (ld_req_i) gnt_o[GNT_LD] = 1'b1;
      end
      RUN: begin
        if (if_req_i && (age_i || !dm_req_i)) gnt_o[GNT_IF] = 1'b1;
        else if (dm_req_i)                     gnt_o[GNT_DM] = 1'b1;
      end
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for IF/DM/LD with run-mode sequencing and fetch aging.
module mips32_mem_arbiter
  import mips32_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_in,
  input  logic             ld_req,
  input  logic             ld_we,
  input  logic [AW-1:0]    ld_addr,
  input  logic [DW-1:0]    ld_wdata,
  output logic             ld_gnt,
  output logic             ld_rvalid,
  output logic [DW-1:0]    ld_rdata,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [DW-1:0]    if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [AW-1:0]    dm_addr,
  input  logic [DW-1:0]    dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [DW-1:0]    dm_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             core_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] if_stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  state_e            state_q;
  logic              core_hold_q;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  req_id_e           owner_q, owner_d;
  logic [GNT_W-1:0]  gnt_raw, gnt;
  logic              age;

  assign age = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  mips32_arb_prio u_prio (
    .state_i  (state_q),
    .ld_req_i (ld_req),
    .dm_req_i (dm_req),
    .if_req_i (if_req),
    .age_i    (age),
    .gnt_o    (gnt_raw)
  );

  // No memory access may be launched while reset is being applied
  assign gnt    = rst ? '0 : gnt_raw;
  assign ld_gnt = gnt[GNT_LD];
  assign dm_gnt = gnt[GNT_DM];
  assign if_gnt = gnt[GNT_IF];
  assign mem_en = |gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[GNT_LD]) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (gnt[GNT_DM]) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (gnt[GNT_IF]) begin
      mem_addr  = if_addr;
    end
  end

  // A read in flight when reset arrives is suppressed, not signalled
  assign ld_rvalid    = !rst && (owner_q == REQ_LD);
  assign dm_rvalid    = !rst && (owner_q == REQ_DM);
  assign if_rvalid    = !rst && (owner_q == REQ_IF);
  assign ld_rdata     = mem_rdata;
  assign dm_rdata     = mem_rdata;
  assign if_rdata     = mem_rdata;
  assign state        = state_q;
  assign core_hold    = core_hold_q;
  assign if_stall_cnt = stall_cnt_q;

  always_comb begin
    owner_d = REQ_NONE;
    if (gnt[GNT_LD] && !ld_we)      owner_d = REQ_LD;
    else if (gnt[GNT_DM] && !dm_we) owner_d = REQ_DM;
    else if (gnt[GNT_IF])           owner_d = REQ_IF;

    wait_cnt_d = wait_cnt_q;
    if (state_q != RUN || halt_in || gnt[GNT_IF]) wait_cnt_d = '0;
    else if (if_req && !age)                      wait_cnt_d = wait_cnt_q + WAIT_W'(1);

    stall_cnt_d = stall_cnt_q;
    if (state_q == RUN && if_req && !gnt[GNT_IF] && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= BOOT;
      core_hold_q <= 1'b1;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      owner_q     <= REQ_NONE;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      owner_q     <= owner_d;
      case (state_q)
        BOOT, HALT: begin
          if (start) begin
            state_q     <= RUN;
            core_hold_q <= 1'b0;
          end
        end
        RUN: begin
          if (halt_in) begin
            state_q     <= HALT;
            core_hold_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= BOOT;
          core_hold_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed self-checking bench for mips32_mem_arbiter with a behavioural 1-cycle memory.
module tb_mips32_mem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk1, rst, start, halt_in;
  logic             ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [AW-1:0]    ld_addr;
  logic [DW-1:0]    ld_wdata, ld_rdata;
  logic             if_req, if_gnt, if_rvalid;
  logic [AW-1:0]    if_addr;
  logic [DW-1:0]    if_rdata;
  logic             dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0]    dm_addr;
  logic [DW-1:0]    dm_wdata, dm_rdata;
  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;
  logic             core_hold;
  logic [1:0]       state;
  logic [CNT_W-1:0] if_stall_cnt;

  logic [DW-1:0] mem [1024];

  int n_cmp;
  int n_err;

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(3), .CNT_W(CNT_W)) dut (
    .clk1(clk1), .rst(rst), .start(start), .halt_in(halt_in),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .core_hold(core_hold), .state(state),
    .if_stall_cnt(if_stall_cnt)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; halt_in = 1'b0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    repeat (2) step();
    chk("rst_state", 32'(state), 0);
    chk("rst_hold", 32'(core_hold), 1);
    chk("rst_memen", 32'(mem_en), 0);
    chk("rst_stall", 32'(if_stall_cnt), 0);
    chk("rst_rvalid", 32'({ld_rvalid, dm_rvalid, if_rvalid}), 0);
    rst = 1'b0;

    // BOOT: loader write then read, core requests ignored
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd0; ld_wdata = 32'h28010063;
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 10'd5;
    #2;
    chk("boot_wr_gnt", 32'({ld_gnt, dm_gnt, if_gnt}), 32'b100);
    chk("boot_wr_we", 32'(mem_we), 1);
    step();
    ld_we = 1'b0;
    #2;
    chk("boot_rd_gnt", 32'({ld_gnt, dm_gnt, if_gnt}), 32'b100);
    chk("boot_wr_novalid", 32'(ld_rvalid), 0);
    step();
    ld_req = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    #2;
    chk("boot_rd_valid", 32'(ld_rvalid), 1);
    chk("boot_rd_data", ld_rdata, 32'h28010063);
    chk("boot_hold", 32'(core_hold), 1);
    chk("boot_state", 32'(state), 0);

    // start, then a fetch of addr 0
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_state", 32'(state), 1);
    chk("run_hold", 32'(core_hold), 0);
    if_req = 1'b1; if_addr = 10'd0;
    #2;
    chk("run_if_gnt", 32'(if_gnt), 1);
    step();
    if_req = 1'b0;
    #2;
    chk("run_if_valid", 32'(if_rvalid), 1);
    chk("run_if_data", if_rdata, 32'h28010063);

    // contention with aging: DM,DM,DM,IF,DM,DM
    step();
    if_req = 1'b1; if_addr = 10'd1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd2;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("age_if_%0d", i), 32'(if_gnt), (i == 3) ? 1 : 0);
      chk($sformatf("age_dm_%0d", i), 32'(dm_gnt), (i == 3) ? 0 : 1);
      if (i == 4) chk("age_wait_clr", 32'(dut.wait_cnt_q), 0);
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    #2;
    chk("age_stall_cnt", 32'(if_stall_cnt), 5);

    // DM write, then DM read coinciding with halt
    step();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd99; dm_wdata = 32'd4;
    #2;
    chk("dm_wr_gnt", 32'(dm_gnt), 1);
    step();
    dm_we = 1'b0; halt_in = 1'b1;
    #2;
    chk("dm_rd_gnt", 32'(dm_gnt), 1);
    step();
    dm_req = 1'b0; halt_in = 1'b0;
    #2;
    chk("halt_dm_valid", 32'(dm_rvalid), 1);
    chk("halt_dm_data", dm_rdata, 32'd4);
    chk("halt_state", 32'(state), 2);
    chk("halt_hold", 32'(core_hold), 1);
    step();
    if_req = 1'b1; if_addr = 10'd5;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd99;
    #2;
    chk("halt_if_gnt", 32'(if_gnt), 0);
    chk("halt_ld_gnt", 32'(ld_gnt), 1);
    step();
    if_req = 1'b0; ld_req = 1'b0;
    #2;
    chk("halt_ld_valid", 32'(ld_rvalid), 1);
    chk("halt_ld_data", ld_rdata, 32'd4);
    chk("halt_if_novalid", 32'(if_rvalid), 0);

    // reset right behind a granted fetch
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rerun_state", 32'(state), 1);
    if_req = 1'b1; if_addr = 10'd0;
    #2;
    chk("rerun_if_gnt", 32'(if_gnt), 1);
    step();
    if_req = 1'b0; rst = 1'b1;
    #2;
    chk("rst_drop_valid0", 32'(if_rvalid), 0);
    step();
    rst = 1'b0;
    #2;
    chk("rst_drop_valid1", 32'(if_rvalid), 0);
    chk("rst2_state", 32'(state), 0);
    chk("rst2_stall", 32'(if_stall_cnt), 0);
    chk("rst2_hold", 32'(core_hold), 1);

    // start together with a loader read in BOOT
    step();
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd99; start = 1'b1;
    #2;
    chk("bs_ld_gnt", 32'(ld_gnt), 1);
    step();
    start = 1'b0; ld_addr = 10'd0;
    #2;
    chk("bs_ld_valid", 32'(ld_rvalid), 1);
    chk("bs_ld_data", ld_rdata, 32'd4);
    chk("bs_state", 32'(state), 1);
    chk("bs_ld_ignored", 32'(ld_gnt), 0);
    step();
    ld_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
- Single-port unified memory controller for the mips32 core. It shares one word-addressed memory between three requesters: instruction fetch (IF), data access (DM, lw/sw), and a loader/debug port (LD).
- It sequences the run modes: boot/program-load, run and halted. It holds the core while the loader owns memory.
- Fetch starvation is bounded by an aging counter.

Parameters:
- AW, 10, memory word-address width (1024 words)
- DW, 32, data width
- MAX_WAIT, 3, consecutive denied IF cycles before IF gets priority for one cycle
- CNT_W, 16, width of IF stall performance counter

Ports:
- clk1  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level; leave BOOT/HALT and enter RUN
- halt_in  in  1  core executed HLT
- ld_req/ld_we  in  1/1  loader request / write enable
- ld_addr/ld_wdata  in  AW/DW  loader address / write data
- ld_gnt/ld_rvalid  out  1/1  loader grant / read data valid
- ld_rdata  out  DW  loader read data
- if_req  in  1  fetch request (read only)
- if_addr  in  AW  fetch address
- if_gnt/if_rvalid  out  1/1  fetch grant / read data valid
- if_rdata  out  DW  fetch read data
- dm_req/dm_we  in  1/1  data request / write enable
- dm_addr/dm_wdata  in  AW/DW  data address / write data
- dm_gnt/dm_rvalid  out  1/1  data grant / read data valid
- dm_rdata  out  DW  data read data
- mem_en/mem_we  out  1/1  memory strobe / write
- mem_addr/mem_wdata  out  AW/DW  memory address / write data
- mem_rdata  in  DW  read data, valid one cycle after mem_en & !mem_we
- core_hold  out  1  stall entire pipeline
- state  out  2  current mode
- if_stall_cnt  out  CNT_W  saturating count of RUN cycles with if_req & !if_gnt

Behaviour:
- Reset values:
  - state=BOOT, core_hold=1
  - all *_gnt=0 and all *_rvalid=0
  - mem_en=0, wait_cnt=0, if_stall_cnt=0
  - a pending read in flight at reset is dropped and never signalled
- Grants are combinational from req and registered state. At most one grant per cycle.
- mem_* is muxed from the granted port. mem_en equals OR of the grants.
- Read latency is 1: x_rvalid is registered high exactly one cycle after a granted read, and x_rdata=mem_rdata in that cycle.
- Writes are complete at the grant edge and produce no rvalid.
- Ungranted requesters hold req/addr/wdata stable until granted.
- BOOT:
  - only LD is served; if_req and dm_req are ignored; core_hold=1
  - start=1 moves to RUN next cycle; an LD access in the same cycle is still granted
- RUN:
  - core_hold=0; LD is ignored (ld_gnt=0)
  - priority is DM over IF, except that IF wins when wait_cnt==MAX_WAIT
  - wait_cnt increments (saturating at MAX_WAIT) each cycle with if_req & !if_gnt, and clears on if_gnt
  - halt_in=1 moves to HALT next cycle; that cycle's access is arbitrated normally and its rvalid still returns
- HALT:
  - core_hold=1; IF and DM are ignored; LD is served
  - start moves to RUN next cycle; wait_cnt clears on HALT entry
- Undefined state encoding returns to BOOT.
- if_stall_cnt increments only in RUN and saturates at all-ones.
- Addresses wrap modulo 2^AW; there are no range checks.

Decomposition:
- Package mips32_arb_pkg holds:
  - state constants BOOT=2'd0, RUN=2'd1, HALT=2'd2
  - requester IDs REQ_NONE/LD/DM/IF
  - default AW/DW
- Sub-module mips32_arb_prio: combinational picker taking the requests, state and the aging flag, and returning a one-hot grant.
- The top level holds the FSM, wait_cnt, the read-owner register, the rvalid pipeline and if_stall_cnt.

Test Plan:
1. Reset, then in BOOT: LD writes mem[0]=32'h28010063, then LD reads addr 0.
   - Required: ld_gnt in the same cycle; ld_rvalid one cycle later with 32'h28010063.
   - Required: if_req/dm_req never granted; core_hold=1.
2. start pulse, then if_req addr 0 in RUN.
   - Required: state=RUN next cycle, core_hold=0, if_gnt=1.
   - Required: if_rvalid next cycle with if_rdata=32'h28010063.
3. if_req and dm_req held continuously for 6 cycles, MAX_WAIT=3.
   - Required: grants DM,DM,DM,IF,DM,DM.
   - Required: wait_cnt=0 after the IF grant; if_stall_cnt=5.
4. DM writes mem[99]=4; halt_in during a DM read of addr 99.
   - Required: dm_rvalid next cycle with 4, then state=HALT.
   - Required: a later if_req is not granted; an LD read of 99 returns 4.
5. rst asserted the cycle after a granted IF read.
   - Required: no if_rvalid; state=BOOT, if_stall_cnt=0, core_hold=1.
6. In BOOT, ld_req and start in the same cycle.
   - Required: LD access granted and its rvalid delivered; state=RUN next cycle.
   - Required: a following ld_req is not granted.
